// File: rtl/stream_mux_rr_if.sv
// ---------------------------------------------------------------------------
// stream_mux_rr_if
//   Handshake bundle for the N-channel stream multiplexer.
//   Parameters: N (channels), W (data width). SELW is derived, never set.
//   Signals:
//     mode      1     0 = fixed select via sel, 1 = round-robin
//     sel       SELW  channel index used in fixed mode
//     in_valid  N     per-channel valid
//     in_data   N*W   channel k at bits [k*W +: W]
//     in_ready  N     per-channel ready (one-hot or zero)
//     out_valid 1     output register holds a beat
//     out_data  W     registered data
//     out_chan  SELW  source channel of out_data
//     out_ready 1     downstream accept
//   With STREAM_MUX_LOCK_EN defined: in_last (N) and out_last (1) are added.
//   Modports: slave = the multiplexer, master = producers + consumer side.
// ---------------------------------------------------------------------------
interface stream_mux_rr_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SELW = (N > 1) ? $clog2(N) : 1;

    logic            mode;
    logic [SELW-1:0] sel;
    logic [N-1:0]    in_valid;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_chan;
    logic            out_ready;
`ifdef STREAM_MUX_LOCK_EN
    logic [N-1:0]    in_last;
    logic            out_last;

    modport slave (
        input  mode, sel, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_chan, out_last
    );
    modport master (
        output mode, sel, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_chan, out_last
    );
`else
    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );
    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );
`endif
endinterface

// File: rtl/stream_mux_rr.sv
// ---------------------------------------------------------------------------
// stream_mux_rr
//   N-channel valid/ready stream multiplexer with a single registered output
//   stage. Fixed (sel) or round-robin selection; each output beat is tagged
//   with its source channel.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset
//     bus  - stream_mux_rr_if.slave (inputs, per-channel ready, output stage)
//   Optional feature macro: STREAM_MUX_LOCK_EN (packet lock using in_last;
//   the grant stays on a channel until its last beat has transferred).
// ---------------------------------------------------------------------------
module stream_mux_rr #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    stream_mux_rr_if.slave bus
);
    localparam int SELW = (N > 1) ? $clog2(N) : 1;

    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q,  out_data_d;
    logic [SELW-1:0] out_chan_q,  out_chan_d;
    logic [SELW-1:0] ptr_q,       ptr_d;

    logic            load_en;
    logic            grant_exists;
    logic [SELW-1:0] grant_idx;
    logic [SELW-1:0] grant_next;
    logic            ready_any;
    logic            xfer;
    logic [SELW-1:0] rr_idx;
    int              rr_k;

`ifdef STREAM_MUX_LOCK_EN
    logic            lock_q, lock_d;
    logic [SELW-1:0] lock_chan_q, lock_chan_d;
    logic            out_last_q, out_last_d;
`endif

    // The single output slot can take a new beat when empty or draining.
    assign load_en = !out_valid_q || bus.out_ready;

    // Grant selection, recomputed every cycle from the current inputs.
    always_comb begin
        grant_exists = 1'b0;
        grant_idx    = '0;
        rr_k         = 0;
        rr_idx       = '0;
        if (N == 1) begin
            grant_exists = 1'b1;
        end else if (!bus.mode) begin
            if (int'(bus.sel) < N) begin
                grant_exists = 1'b1;
                grant_idx    = bus.sel;
            end
        end else begin
            // Walk from the farthest offset back to ptr so the channel
            // nearest the pointer is the one left standing.
            for (int i = N - 1; i >= 0; i--) begin
                rr_k = int'(ptr_q) + i;
                if (rr_k >= N) begin
                    rr_k = rr_k - N;
                end
                rr_idx = SELW'(rr_k);
                if (bus.in_valid[rr_idx]) begin
                    grant_exists = 1'b1;
                    grant_idx    = rr_idx;
                end
            end
        end
`ifdef STREAM_MUX_LOCK_EN
        // A packet in flight owns the output regardless of mode/sel.
        if (lock_q) begin
            grant_exists = 1'b1;
            grant_idx    = lock_chan_q;
        end
`endif
    end

    assign ready_any  = grant_exists && load_en && !rst;
    assign xfer       = ready_any && bus.in_valid[grant_idx];
    assign grant_next = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;

    // Ready depends only on the grant, never on the channel's own valid.
    for (genvar gi = 0; gi < N; gi++) begin : g_ready
        assign bus.in_ready[gi] = ready_any && (grant_idx == SELW'(gi));
    end

    // Next-state logic for the output stage, pointer and lock.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
`ifdef STREAM_MUX_LOCK_EN
        lock_d      = lock_q;
        lock_chan_d = lock_chan_q;
        out_last_d  = out_last_q;
`endif
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data[int'(grant_idx) * W +: W];
            out_chan_d  = grant_idx;
`ifdef STREAM_MUX_LOCK_EN
            out_last_d  = bus.in_last[grant_idx];
            lock_d      = !bus.in_last[grant_idx];
            lock_chan_d = grant_idx;
            // Fairness advances only once a whole packet has gone through.
            if (bus.mode && bus.in_last[grant_idx]) begin
                ptr_d = grant_next;
            end
`else
            if (bus.mode) begin
                ptr_d = grant_next;
            end
`endif
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
`ifdef STREAM_MUX_LOCK_EN
            lock_q      <= 1'b0;
            lock_chan_q <= '0;
            out_last_q  <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
`ifdef STREAM_MUX_LOCK_EN
            lock_q      <= lock_d;
            lock_chan_q <= lock_chan_d;
            out_last_q  <= out_last_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
`ifdef STREAM_MUX_LOCK_EN
    assign bus.out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// ---------------------------------------------------------------------------
// tb_stream_mux_rr
//   Table-driven check of stream_mux_rr (N=4, W=8) with a scoreboard queue,
//   plus hand-written sequences for reset, an N=3 instance and packet lock.
// ---------------------------------------------------------------------------
module tb_stream_mux_rr;
    localparam logic [31:0] DC = 32'hD3C2_B1A0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_mux_rr_if #(.N(4), .W(8)) bus ();
    stream_mux_rr_if #(.N(3), .W(8)) bus3 ();

    stream_mux_rr #(.N(4), .W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    stream_mux_rr #(.N(3), .W(8)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        oready;
        logic [3:0]  exp_ready;
    } vec_t;

    vec_t       vecs[$];
    logic [9:0] sb[$];      // {chan[1:0], data[7:0]}
    logic       mdl_ov = 1'b0;
    int         cmp_cnt = 0;
    int         err_cnt = 0;

    function automatic vec_t mk(input logic m, input logic [1:0] s, input logic [3:0] v,
                                input logic [31:0] d, input logic r, input logic [3:0] e);
        vec_t t;
        t.mode = m; t.sel = s; t.valid = v; t.data = d; t.oready = r; t.exp_ready = e;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check at negedge+1, update the model.
    task automatic step(input vec_t v);
        logic [9:0] e;
        logic [3:0] x;
        @(negedge clk);
        rst           = 1'b0;
        bus.mode      = v.mode;
        bus.sel       = v.sel;
        bus.in_valid  = v.valid;
        bus.in_data   = v.data;
        bus.out_ready = v.oready;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(v.exp_ready));
        chk("out_valid", 32'(bus.out_valid), 32'(mdl_ov));
        if (mdl_ov) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 32'(0), 32'(1));
            end else begin
                e = sb[0];
                chk("out_data", 32'(bus.out_data), 32'(e[7:0]));
                chk("out_chan", 32'(bus.out_chan), 32'(e[9:8]));
                if (v.oready) void'(sb.pop_front());
            end
        end
        x = v.exp_ready & v.valid;
        for (int k = 0; k < 4; k++) begin
            if (x[k]) sb.push_back({2'(k), v.data[k*8 +: 8]});
        end
        if (x != 4'd0) mdl_ov = 1'b1;
        else if (v.oready) mdl_ov = 1'b0;
        $display("step mode=%0d sel=%0d valid=%b oready=%0d in_ready=%b out_valid=%0d out_chan=%0d out_data=%h",
                 v.mode, v.sel, v.valid, v.oready, bus.in_ready, bus.out_valid, bus.out_chan, bus.out_data);
    endtask

    initial begin
        // Fixed select, stepping sel 0..3.
        vecs.push_back(mk(0, 0, 4'hF, DC, 1, 4'b0001));
        vecs.push_back(mk(0, 1, 4'hF, DC, 1, 4'b0010));
        vecs.push_back(mk(0, 2, 4'hF, DC, 1, 4'b0100));
        vecs.push_back(mk(0, 3, 4'hF, DC, 1, 4'b1000));
        // Round-robin, all valid, 8 cycles.
        for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 0, 4'hF, DC, 1, 4'(1 << (i % 4))));
        // Lone ch2, then back-pressure with mode/sel toggling, then release.
        vecs.push_back(mk(1, 0, 4'b0100, 32'h0055_0000, 1, 4'b0100));
        vecs.push_back(mk(1, 0, 4'b0100, 32'h0066_0000, 0, 4'b0000));
        vecs.push_back(mk(0, 1, 4'b0100, 32'h0066_0000, 0, 4'b0000));
        vecs.push_back(mk(1, 3, 4'b0100, 32'h0066_0000, 0, 4'b0000));
        vecs.push_back(mk(1, 0, 4'b0100, 32'h0066_0000, 1, 4'b0100));
        vecs.push_back(mk(1, 0, 4'b0000, 32'h0, 1, 4'b0000));
        // Fixed select of an idle channel: ready without transfer.
        vecs.push_back(mk(0, 2, 4'b1011, DC, 1, 4'b0100));
        vecs.push_back(mk(0, 2, 4'b1011, DC, 1, 4'b0100));
        vecs.push_back(mk(0, 1, 4'b0000, DC, 1, 4'b0010));
        // Pointer held through fixed mode (ptr=3), then sparse requests.
        vecs.push_back(mk(1, 0, 4'hF,    DC, 1, 4'b1000));
        vecs.push_back(mk(1, 0, 4'b1010, DC, 1, 4'b0010));
        vecs.push_back(mk(1, 0, 4'b1010, DC, 1, 4'b1000));
        vecs.push_back(mk(1, 0, 4'b0000, DC, 1, 4'b0000));
        // Load ch2 and hold it (ptr becomes 3) ahead of a mid-flight reset.
        vecs.push_back(mk(1, 0, 4'b0100, DC, 0, 4'b0100));

        bus.mode = 1'b1; bus.sel = '0; bus.in_valid = 4'hF; bus.in_data = DC; bus.out_ready = 1'b1;
        bus3.mode = 1'b0; bus3.sel = '0; bus3.in_valid = '0; bus3.in_data = '0; bus3.out_ready = 1'b1;
`ifdef STREAM_MUX_LOCK_EN
        bus.in_last = '1;
        bus3.in_last = '1;
`endif
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_out_data", 32'(bus.out_data), 32'(0));
        chk("rst_out_chan", 32'(bus.out_chan), 32'(0));

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // Reset while a beat is held.
        @(negedge clk);
        rst = 1'b1; bus.mode = 1'b1; bus.in_valid = 4'hF; bus.out_ready = 1'b1;
        #1;
        chk("pre_rst_out_valid", 32'(bus.out_valid), 32'(mdl_ov));
        chk("midrst_in_ready", 32'(bus.in_ready), 32'(0));
        @(negedge clk);
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("midrst_out_chan", 32'(bus.out_chan), 32'(0));
        chk("midrst_out_data", 32'(bus.out_data), 32'(0));
        $display("reset mid-operation: out_valid=%0d out_chan=%0d", bus.out_valid, bus.out_chan);
        sb.delete();
        mdl_ov = 1'b0;
        step(mk(1, 0, 4'hF, DC, 1, 4'b0001));
        step(mk(1, 0, 4'hF, DC, 1, 4'b0010));
        step(mk(1, 0, 4'h0, DC, 1, 4'b0000));

        // N=3: out-of-range select grants nothing.
        @(negedge clk);
        bus3.mode = 1'b0; bus3.sel = 2'd3; bus3.in_valid = 3'b111; bus3.in_data = 24'hC2B1A0;
        #1;
        chk("n3_sel3_in_ready", 32'(bus3.in_ready), 32'(0));
        @(negedge clk);
        #1;
        chk("n3_sel3_out_valid", 32'(bus3.out_valid), 32'(0));
        bus3.sel = 2'd1;
        #1;
        chk("n3_sel1_in_ready", 32'(bus3.in_ready), 32'(3'b010));
        $display("n3 check: in_ready=%b", bus3.in_ready);

`ifdef STREAM_MUX_LOCK_EN
        // ch1 packet of 3 beats; mode/sel toggle mid-packet, ptr=2 afterwards.
        bus.in_last = 4'b0000;
        step(mk(0, 1, 4'b1011, DC, 1, 4'b0010));
        step(mk(1, 0, 4'b1011, DC, 1, 4'b0010));
        bus.in_last = 4'b1111;
        step(mk(0, 3, 4'b1011, DC, 1, 4'b0010));
        step(mk(1, 0, 4'b1001, DC, 1, 4'b1000));
        step(mk(1, 0, 4'b0000, DC, 1, 4'b0000));
`endif

        step(mk(1, 0, 4'b0000, DC, 1, 4'b0000));
        chk("sb_drained", 32'(sb.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
